// File: rtl/gen_pkg.sv
// Shared types and helpers for generator-protocol stages.
package gen_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    CALL,
    PULL0,
    PULL,
    EMIT,
    FLUSH,
    DONE
  } chunk_sum_state_t;

  // A stage may move on when its output slot is free or being drained this cycle.
  function automatic logic can_advance(input logic ready, input logic valid);
    return ready || !valid;
  endfunction

endpackage

// File: rtl/gen_out_reg.sv
// Output tuple register of a generator stage: valid drops when the caller
// takes the tuple, and a load sets a fresh tuple and valid together.
module gen_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ready,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] d0,
  input  logic signed [WIDTH-1:0] d1,
  output logic                    valid,
  output logic signed [WIDTH-1:0] out0,
  output logic signed [WIDTH-1:0] out1
);

  // Tuple register; a load wins over the ready-driven clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      out0  <= '0;
      out1  <= '0;
    end else begin
      if (ready) valid <= 1'b0;
      if (load) begin
        valid <= 1'b1;
        out0  <= d0;
        out1  <= d1;
      end
    end
  end

endmodule

// File: rtl/chunk_sum.sv
// Chunked sum stage: consumes the upstream value stream and yields
// (sum, count) for every k values, plus a final partial chunk if any remain.
module chunk_sum #(
  parameter int WIDTH = gen_pkg::WIDTH
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] n,
  input  logic signed [WIDTH-1:0] k,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic signed [WIDTH-1:0] _up_n,
  output logic                    _up_start,
  output logic                    _up_ready,
  input  logic                    _up_valid,
  input  logic                    _up_done,
  input  logic signed [WIDTH-1:0] _up_out0
);
  import gen_pkg::*;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  chunk_sum_state_t       state, state_d;
  logic signed [WIDTH-1:0] acc, acc_d;
  logic signed [WIDTH-1:0] cnt, cnt_d;
  logic signed [WIDTH-1:0] n_reg, n_d;
  logic signed [WIDTH-1:0] k_reg, k_d;
  logic                    up_start_r, up_start_d;
  logic                    up_ready_r, up_ready_d;
  logic                    load;
  logic                    accept;
  logic signed [WIDTH-1:0] cnt_inc;
  logic                    out_rst;

  assign accept    = _up_valid && up_ready_r;
  assign cnt_inc   = cnt + ONE;
  assign out_rst   = _reset && !_start;
  assign _up_n     = n_reg;
  assign _up_start = up_start_r;
  assign _up_ready = up_ready_r;
  assign _done     = (state == DONE);

  // Next-state and datapath updates; everything holds while the output stalls.
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    cnt_d      = cnt;
    n_d        = n_reg;
    k_d        = k_reg;
    up_start_d = up_start_r;
    up_ready_d = up_ready_r;
    load       = 1'b0;
    if (_start) begin
      n_d        = n;
      k_d        = (k[WIDTH-1] || k == '0) ? ONE : k;
      acc_d      = '0;
      cnt_d      = '0;
      up_start_d = 1'b0;
      up_ready_d = 1'b0;
      state_d    = CALL;
    end else if (can_advance(_ready, _valid)) begin
      case (state)
        CALL: begin
          up_start_d = 1'b1;
          up_ready_d = 1'b0;
          state_d    = PULL0;
        end
        PULL0, PULL: begin
          up_start_d = 1'b0;
          up_ready_d = 1'b1;
          state_d    = PULL;
          if (accept) begin
            acc_d      = acc + _up_out0;
            cnt_d      = cnt_inc;
            up_ready_d = 1'b0;
            if (cnt_inc == k_reg) state_d = EMIT;
          end else if (state == PULL && _up_done) begin
            // upstream done is stale right after its start, so PULL0 ignores it
            state_d = FLUSH;
          end
        end
        EMIT: begin
          load    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = PULL;
        end
        FLUSH: begin
          load       = !cnt[WIDTH-1] && cnt != '0;
          acc_d      = '0;
          cnt_d      = '0;
          up_ready_d = 1'b0;
          state_d    = DONE;
        end
        DONE: begin
          up_ready_d = 1'b0;
        end
        default: state_d = DONE;
      endcase
    end
  end

  // State register; start outranks reset in the same cycle.
  always_ff @(posedge _clock) begin
    if (out_rst) begin
      state      <= DONE;
      acc        <= '0;
      cnt        <= '0;
      up_start_r <= 1'b0;
      up_ready_r <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      cnt        <= cnt_d;
      n_reg      <= n_d;
      k_reg      <= k_d;
      up_start_r <= up_start_d;
      up_ready_r <= up_ready_d;
    end
  end

  gen_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk   (_clock),
    .rst   (out_rst),
    .ready (_ready),
    .load  (load),
    .d0    (acc),
    .d1    (cnt),
    .valid (_valid),
    .out0  (_out0),
    .out1  (_out1)
  );

endmodule

// File: tb/tb_chunk_sum.sv
// Bench for chunk_sum with a behavioural range-generator upstream.
module tb_chunk_sum;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, start, ready;
  logic signed [W-1:0] n_in, k_in;
  logic                valid, done;
  logic signed [W-1:0] out0, out1, up_n;
  logic                up_start, up_ready;
  logic                up_valid = 1'b0;
  logic                up_done;
  logic signed [W-1:0] up_out0 = '0;

  int vectors = 0;
  int miscompares = 0;
  int exp_s[$];
  int exp_c[$];

  chunk_sum #(.WIDTH(W)) dut (
    ._clock   (clk),
    ._reset   (rst),
    ._start   (start),
    .n        (n_in),
    .k        (k_in),
    ._ready   (ready),
    ._valid   (valid),
    ._done    (done),
    ._out0    (out0),
    ._out1    (out1),
    ._up_n    (up_n),
    ._up_start(up_start),
    ._up_ready(up_ready),
    ._up_valid(up_valid),
    ._up_done (up_done),
    ._up_out0 (up_out0)
  );

  // Upstream generator: yields 0..n-1 with the same start/ready/valid/done protocol.
  int u_i = 0;
  int u_n = 0;
  bit u_run = 1'b0;
  assign up_done = !u_run;
  always @(posedge clk) begin
    if (up_start) begin
      u_run <= 1'b1; u_i <= 0; u_n <= up_n; up_valid <= 1'b0;
    end else if (rst) begin
      u_run <= 1'b0; up_valid <= 1'b0; up_out0 <= '0;
    end else begin
      if (up_ready) up_valid <= 1'b0;
      if (u_run && (up_ready || !up_valid)) begin
        if (u_i < u_n) begin
          up_out0 <= u_i; up_valid <= 1'b1; u_i <= u_i + 1;
        end else begin
          u_run <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: chunk the range 0..n-1 into groups of max(k,1), keep a partial tail.
  task automatic build_expected(input int n, input int k);
    int kk, acc, c;
    exp_s.delete(); exp_c.delete();
    kk = (k < 1) ? 1 : k;
    acc = 0; c = 0;
    for (int i = 0; i < n; i++) begin
      acc += i; c++;
      if (c == kk) begin exp_s.push_back(acc); exp_c.push_back(c); acc = 0; c = 0; end
    end
    if (c != 0) begin exp_s.push_back(acc); exp_c.push_back(c); end
  endtask

  task automatic run(input int n, input int k, input bit rnd, input int stop_after,
                     input int max_done);
    int got_s[$];
    int got_c[$];
    int pulses, done_at;
    bit finished, stall;
    longint h0, h1;
    pulses = 0; done_at = -1; finished = 1'b0; stall = 1'b0; h0 = 0; h1 = 0;
    build_expected(n, k);
    @(negedge clk);
    start = 1'b1; n_in = n; k_in = k; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; n_in = $urandom; k_in = $urandom;
    for (int c = 0; c < 600; c++) begin
      if (stall) begin
        check("stall_valid", valid, 1);
        check("stall_out0", out0, h0);
        check("stall_out1", out1, h1);
      end
      if (up_start) begin
        pulses++;
        check("up_n", up_n, n);
      end
      if (done && !valid) begin done_at = c; finished = 1'b1; break; end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = valid && !ready;
      h0 = out0; h1 = out1;
      if (valid && ready) begin
        got_s.push_back(out0); got_c.push_back(out1);
        if (got_s.size() == stop_after) begin finished = 1'b1; break; end
      end
      @(negedge clk);
    end
    check("finished", finished, 1);
    check("up_start_pulses", pulses, 1);
    if (stop_after < 0) check("tuple_count", got_s.size(), exp_s.size());
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
      check("sum", got_s[i], exp_s[i]);
      check("cnt", got_c[i], exp_c[i]);
    end
    if (max_done > 0) check("done_latency_ok", (done_at >= 0 && done_at + 1 <= max_done), 1);
    if (stop_after < 0) begin
      ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("idle_valid", valid, 0);
        check("idle_done", done, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; n_in = '0; k_in = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done, 1);
    check("rst_valid", valid, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_up_start", up_start, 0);
    check("rst_up_ready", up_ready, 0);
    rst = 1'b0;

    run(10, 3, 1'b0, -1, 0);
    run(10, 5, 1'b0, -1, 0);
    run(0, 4, 1'b0, -1, 6);
    run(3, 0, 1'b0, -1, 0);
    run(10, 3, 1'b1, -1, 0);
    run(5, -4, 1'b1, -1, 0);

    run(10, 3, 1'b0, 2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_done", done, 1);
    check("midrst_valid", valid, 0);
    check("midrst_up_ready", up_ready, 0);
    check("midrst_out0", out0, 0);
    run(4, 2, 1'b0, -1, 0);

    for (int r = 0; r < 6; r++) begin
      int rn, rk;
      rn = int'($urandom_range(0, 14));
      rk = int'($urandom_range(0, 7)) - 2;
      run(rn, rk, 1'b1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chunk_sum.md
Name: chunk_sum

Overview:
- Streaming generator stage that sits directly downstream of a dup_range_goal-style generator and consumes its tuple stream.
- It yields (sum, count) for every k consecutive upstream values, then one final partial chunk if any values remain.
- Python equivalent: acc=0; cnt=0; for i in dup_range_goal(n): acc+=i; cnt+=1; if cnt==k: yield acc,cnt; acc=cnt=0. After the loop: if cnt: yield acc,cnt.
- Exposes the same start/ready/valid/done generator protocol as every generated module. It also drives the upstream instance's start/ready.

Parameters:
- WIDTH, 32, width of n, k, the upstream data, the sum and the count (all signed).

Ports:
- _clock  in  1  single clock; all logic on posedge.
- _reset  in  1  synchronous, active-high reset; forces the done state.
- _start  in  1  captures n and k in the same cycle and begins generation.
- n  in  WIDTH  element count forwarded to upstream; sampled only when _start is high.
- k  in  WIDTH  chunk size; sampled only when _start is high.
- _ready  in  1  caller is ready for output.
- _valid  out  1  _out0/_out1 hold a valid tuple.
- _done  out  1  high while state is done.
- _out0  out  WIDTH  chunk sum.
- _out1  out  WIDTH  chunk element count.
- _up_n  out  WIDTH  n driven to the upstream instance.
- _up_start  out  1  upstream start pulse.
- _up_ready  out  1  ready to the upstream instance.
- _up_valid  in  1  upstream output valid.
- _up_done  in  1  upstream done.
- _up_out0  in  WIDTH  upstream value i; upstream _out1 is left unconnected.

Behaviour:
- Reset values: state=DONE, _valid=0, _out0=0, _out1=0, _up_start=0, _up_ready=0, acc=0, cnt=0.
- _start takes precedence over _reset in the same cycle.
- On _start:
  - latch _n=n;
  - latch _k = (k<1 ? 1 : k);
  - clear acc and cnt;
  - state→CALL.
- Output handshake:
  - If _ready is high, _valid is cleared to 0 in that cycle.
  - States advance only when (_ready || !_valid); otherwise all registers hold, so _out0/_out1 stay stable while _valid && !_ready.
- States:
  - CALL: _up_start=1, _up_ready=0, _up_n=_n; next state is PULL0.
  - PULL0: _up_start=0, _up_ready=1. _up_done is ignored here because it is stale in the cycle after start. Accept data if _up_valid && _up_ready, otherwise stay in PULL. Go to PULL.
  - PULL:
    - _up_ready=1.
    - Accept: when _up_valid && _up_ready:
      - acc+=_up_out0 (wraps mod 2^WIDTH), cnt+=1, _up_ready=0;
      - if cnt+1==_k, state→EMIT, else stay in PULL.
    - Acceptance has priority over _up_done in the same cycle.
    - Else if _up_done: state→FLUSH.
  - EMIT: _out0=acc, _out1=cnt, _valid=1, acc=0, cnt=0; state→PULL.
  - FLUSH:
    - if cnt>0: _out0=acc, _out1=cnt, _valid=1, clear acc and cnt, state→DONE;
    - else state→DONE with no output.
  - DONE: hold; _up_ready=0.
- _done = (state==DONE) combinationally. The last tuple's _valid is therefore visible together with _done, matching upstream semantics.
- Latency:
  - _up_start occurs 1 cycle after _start.
  - Each emitted tuple appears 1 cycle after the k-th acceptance.
  - The flush tuple appears 1 cycle after _up_done is observed.
- Reset mid-operation: DONE on the next edge, _valid=0, _up_ready=0. The upstream instance shares _reset and also goes done.
- Negative values are allowed; the sum is a signed two's-complement wrap.

Decomposition:
- Shared package gen_pkg:
  - chunk_sum_state_t enum {CALL, PULL0, PULL, EMIT, FLUSH, DONE};
  - localparam WIDTH default 32;
  - handshake helper function can_advance(ready, valid).
- One natural sub-module: gen_out_reg, the output tuple register implementing the _valid clear/set and stall rule. It is reusable by every generator stage.
- The upstream generator is instantiated by the parent (the test top), not inside chunk_sum.

Test Plan:
- n=10, k=3, _ready=1 → tuples (3,3),(12,3),(21,3),(9,1), then _done=1. No further _valid.
- n=10, k=5 → (10,5),(35,5), done with no flush tuple.
- n=0, k=4 → zero tuples; _done within 6 cycles of _start; _up_start pulsed exactly once.
- k=0 → treated as 1; n=3 yields (0,1),(1,1),(2,1).
- n=10, k=3 with pseudo-random _ready (50%) → same four tuples in order; _out0/_out1 unchanged on every cycle with _valid && !_ready.
- Reset asserted the cycle after the 2nd tuple → next cycle _done=1, _valid=0. Then _start with n=4, k=2 → (1,2),(5,2), done.
